// File: rtl/ram_burst_reader.sv
// Burst reader: streams `length` consecutive words from a single-port synchronous RAM,
// wrapping at DEPTH-1, through a 2-entry skid buffer with valid/ready back-pressure.
module ram_burst_reader #(
  parameter  int SIZE  = 8,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   start_address,
  input  logic [LW-1:0]   length,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   ram_address,
  output logic            ram_write_en,
  input  logic [SIZE-1:0] ram_read_data,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      occ_q, occ_d;
  logic [SIZE-1:0] buf0_q, buf0_d;
  logic [SIZE-1:0] buf1_q, buf1_d;
  logic [AW-1:0]   next_addr_q, next_addr_d;
  logic [AW-1:0]   addr_hold_q, addr_hold_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [LW-1:0]   left_q, left_d;

  logic            pop;
  logic            issue;
  logic [1:0]      slot;

  always_comb begin
    pop   = (occ_q != 2'd0) && out_ready;
    // Issue only if the word it returns is guaranteed a buffer slot next cycle.
    issue = (state_q == READ) && (rem_q != '0) &&
            (({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
    slot  = occ_q - {1'b0, pop};

    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    inflight_d  = issue;
    occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    next_addr_d = next_addr_q;
    addr_hold_d = addr_hold_q;
    rem_d       = rem_q;
    left_d      = left_q;

    if (pop && (occ_q == 2'd2)) begin
      buf0_d = buf1_q;
    end
    if (inflight_q) begin
      if (slot == 2'd0) begin
        buf0_d = ram_read_data;
      end else begin
        buf1_d = ram_read_data;
      end
    end

    if (issue) begin
      addr_hold_d = next_addr_q;
      next_addr_d = (next_addr_q == AW'(DEPTH - 1)) ? '0 : next_addr_q + AW'(1);
      rem_d       = rem_q - LW'(1);
    end
    if (pop) begin
      left_d = left_q - LW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            next_addr_d = start_address;
            rem_d       = length;
            left_d      = length;
            busy_d      = 1'b1;
            state_d     = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue && (rem_q == LW'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (left_q == LW'(1))) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      next_addr_q <= '0;
      addr_hold_q <= '0;
      rem_q       <= '0;
      left_q      <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      next_addr_q <= next_addr_d;
      addr_hold_q <= addr_hold_d;
      rem_q       <= rem_d;
      left_q      <= left_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign ram_address  = issue ? next_addr_q : addr_hold_q;
  assign ram_write_en = 1'b0;
  assign out_data     = buf0_q;
  assign out_valid    = (occ_q != 2'd0);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with DEPTH=10 and a synchronous RAM holding RAM[i]=i.
module tb_ram_burst_reader;
  localparam int SIZE  = 8;
  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int LW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   start_address;
  logic [LW-1:0]   length;
  logic            busy;
  logic            done;
  logic [AW-1:0]   ram_address;
  logic            ram_write_en;
  logic [SIZE-1:0] ram_read_data;
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_burst_reader #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .start_address(start_address),
    .length(length), .busy(busy), .done(done), .ram_address(ram_address),
    .ram_write_en(ram_write_en), .ram_read_data(ram_read_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  logic [SIZE-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = SIZE'(i);
  always @(posedge clk) ram_read_data <= mem[ram_address];

  logic            got_valid [128];
  logic            got_busy  [128];
  logic            got_done  [128];
  logic            got_rdy   [128];
  logic [SIZE-1:0] got_data  [128];
  logic [AW-1:0]   got_addr  [128];
  logic [SIZE-1:0] stream [$];
  int last_k, stall_issues, stall_bad, wen_bad, n_done, n_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic record(input int k);
    got_valid[k] = out_valid;
    got_busy[k]  = busy;
    got_done[k]  = done;
    got_rdy[k]   = out_ready;
    got_data[k]  = out_data;
    got_addr[k]  = ram_address;
    if (ram_write_en !== 1'b0) wen_bad++;
    if (out_valid && out_ready) stream.push_back(out_data);
    if (k > 0 && got_valid[k-1] && !got_rdy[k-1] &&
        (!out_valid || out_data !== got_data[k-1])) stall_bad++;
    if (k > 0 && !out_ready && ram_address != got_addr[k-1]) stall_issues++;
  endtask

  // mode: 0 ready=1, 1 stall 10 cycles at first valid, 2 random, 3 toggle, 4 ready=1 + start pulse mid-burst
  task automatic run_burst(input logic [AW-1:0] sa, input logic [LW-1:0] len,
                           input int mode, input int rst_xfers, input int ncyc);
    int fv;
    logic rst_now;
    fv = -1;
    stream.delete();
    stall_issues = 0;
    stall_bad    = 0;
    last_k       = ncyc - 1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1; start_address = sa; length = len; out_ready = 1'b1;
    @(negedge clk); record(0);
    for (int k = 1; k < ncyc; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 4 && k == 2) begin
        start = 1'b1; start_address = '0; length = LW'(3);
      end
      if (fv < 0 && out_valid) fv = k;
      case (mode)
        1:       out_ready = !(fv >= 0 && k < fv + 10);
        2:       out_ready = ($urandom_range(0, 1) == 1);
        3:       out_ready = ((k % 2) == 1);
        default: out_ready = 1'b1;
      endcase
      rst_now = (rst_xfers > 0) && (stream.size() == rst_xfers);
      if (rst_now) begin
        rst = 1'b1; out_ready = 1'b0;
      end
      @(negedge clk); record(k);
      if (rst_now) begin
        last_k = k;
        break;
      end
    end
    start = 1'b0;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i <= last_k; i++) begin
      if (got_done[i]) n_done++;
      if (got_busy[i]) n_busy++;
    end
  endtask

  task automatic check_stream(input string tag, input int sa, input int len);
    chk({tag, "_count"}, 32'(stream.size()), 32'(len));
    for (int j = 0; j < len && j < stream.size(); j++)
      chk({tag, "_word"}, 32'(stream[j]), 32'((sa + j) % DEPTH));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_address = '0; length = '0; out_ready = 1'b0;
    wen_bad = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_addr", 32'(ram_address), 0);
    chk("rst_data", 32'(out_data), 0);

    // start in the first cycle after reset falls, 3 words from address 4
    run_burst(4'd4, 5'd3, 0, 0, 20);
    chk("a_addr_t1", 32'(got_addr[1]), 4);
    chk("a_valid_t2", 32'(got_valid[2]), 0);
    chk("a_valid_t3", 32'(got_valid[3]), 1);
    chk("a_data_t3", 32'(got_data[3]), 4);
    chk("a_data_t4", 32'(got_data[4]), 5);
    chk("a_valid_t5", 32'(got_valid[5]), 1);
    chk("a_data_t5", 32'(got_data[5]), 6);
    chk("a_busy_t5", 32'(got_busy[5]), 1);
    chk("a_done_t6", 32'(got_done[6]), 1);
    chk("a_busy_t6", 32'(got_busy[6]), 0);
    chk("a_valid_t6", 32'(got_valid[6]), 0);
    chk("a_ndone", 32'(n_done), 1);
    check_stream("a", 4, 3);

    // wrap: 8,9,0,1 on both the address bus and the stream
    run_burst(4'd8, 5'd4, 0, 0, 20);
    chk("b_addr1", 32'(got_addr[1]), 8);
    chk("b_addr2", 32'(got_addr[2]), 9);
    chk("b_addr3", 32'(got_addr[3]), 0);
    chk("b_addr4", 32'(got_addr[4]), 1);
    chk("b_valid_t6", 32'(got_valid[6]), 1);
    chk("b_done_t7", 32'(got_done[7]), 1);
    check_stream("b", 8, 4);

    // 10-cycle stall right after first valid, length beyond DEPTH
    run_burst(4'd0, 5'd16, 1, 0, 60);
    chk("c_stall_issues_le2", 32'(stall_issues <= 2), 1);
    chk("c_stall_stable", 32'(stall_bad), 0);
    chk("c_ndone", 32'(n_done), 1);
    check_stream("c", 0, 16);

    run_burst(4'd3, 5'(DEPTH), 2, 0, 120);
    chk("d_stall_stable", 32'(stall_bad), 0);
    chk("d_ndone", 32'(n_done), 1);
    chk("d_busy_end", 32'(got_busy[last_k]), 0);
    check_stream("d", 3, DEPTH);

    run_burst(4'd5, 5'd7, 3, 0, 60);
    chk("e_stall_stable", 32'(stall_bad), 0);
    chk("e_ndone", 32'(n_done), 1);
    check_stream("e", 5, 7);

    // a start pulse while busy must not disturb the running burst
    run_burst(4'd6, 5'd5, 4, 0, 30);
    chk("f_ndone", 32'(n_done), 1);
    check_stream("f", 6, 5);

    run_burst(4'd2, 5'd0, 0, 0, 10);
    chk("g_done_t1", 32'(got_done[1]), 1);
    chk("g_ndone", 32'(n_done), 1);
    chk("g_nbusy", 32'(n_busy), 0);
    chk("g_nwords", 32'(stream.size()), 0);

    // reset after 2 words of an 8-word burst, then a fresh burst right away
    run_burst(4'd1, 5'd8, 0, 2, 40);
    chk("h_ndone_aborted", 32'(n_done), 0);
    check_stream("h_pre", 1, 2);
    run_burst(4'd7, 5'd5, 0, 0, 30);
    chk("h_valid_after_rst", 32'(got_valid[0]), 0);
    chk("h_busy_after_rst", 32'(got_busy[0]), 0);
    chk("h_done_after_rst", 32'(got_done[0]), 0);
    chk("h_addr_t1", 32'(got_addr[1]), 7);
    chk("h_ndone", 32'(n_done), 1);
    check_stream("h", 7, 5);

    chk("write_en_low", 32'(wen_bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
